// File: rtl/uart_pixel_framer_pkg.sv
// uart_pixel_framer_pkg: shared types and constants for the UART pixel framer.
//   framer_state_e : byte-parser states (HUNT, HDR, PIX)
//   HDR0_DEF/HDR1_DEF : default frame header byte values
//   pixel_count()  : number of pixels in a panel
package uart_pixel_framer_pkg;

    typedef enum logic [1:0] {HUNT, HDR, PIX} framer_state_e;

    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

    function automatic int pixel_count(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/uart_pixel_framer.sv
// uart_pixel_framer: turns a UART byte stream (header A5 5A + R,G,B bytes per pixel)
// into framed RGB pixel beats with SOF/EOF marking, backpressure and idle-timeout resync.
//   clk, rst_n (async, active-low)
//   in_valid/in_ready/in_data    : byte stream from the UART receiver
//   pix_valid/pix_ready/pix_rgb  : pixel beat, {B,G,R} with R in the low bits
//   pix_sof/pix_eof              : beat is first/last pixel of the frame
//   frame_done, err_timeout, err_hdr : single-cycle status pulses
module uart_pixel_framer
    import uart_pixel_framer_pkg::*;
#(
    parameter int         COLOR_DEPTH    = 4,
    parameter int         PANEL_ROWS     = 64,
    parameter int         PANEL_COLS     = 64,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] HDR0           = HDR0_DEF,
    parameter logic [7:0] HDR1           = HDR1_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [3*COLOR_DEPTH-1:0] pix_rgb,
    output logic                     pix_sof,
    output logic                     pix_eof,
    output logic                     frame_done,
    output logic                     err_timeout,
    output logic                     err_hdr
);

    localparam int NPIX = pixel_count(PANEL_ROWS, PANEL_COLS);
    localparam int IW   = NPIX > 1 ? $clog2(NPIX) : 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    framer_state_e              state, state_nx;
    logic [1:0]                 ch;
    logic [IW-1:0]              pix_idx;
    logic [2*COLOR_DEPTH-1:0]   acc_rg;
    logic [TW-1:0]              tcnt;
    logic [COLOR_DEPTH-1:0]     chan;
    logic                       take, idle_tick, timeout, last_pix, load, hdr_bad;

    assign in_ready  = !(pix_valid && !pix_ready);
    assign take      = in_valid && in_ready;
    assign chan      = in_data[7 -: COLOR_DEPTH];
    // in_ready=1 with nothing accepted means the host is idle, not stalled by us
    assign idle_tick = (state != HUNT) && in_ready && !in_valid;
    assign timeout   = idle_tick && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_pix  = pix_idx == IW'(NPIX - 1);
    assign load      = take && (state == PIX) && (ch == 2'd2);

    always_comb begin
        state_nx = state;
        hdr_bad  = 1'b0;
        if (timeout)
            state_nx = HUNT;
        else if (take) begin
            case (state)
                HUNT: state_nx = (in_data == HDR0) ? HDR : HUNT;
                HDR: begin
                    state_nx = (in_data == HDR1) ? PIX : (in_data == HDR0) ? HDR : HUNT;
                    hdr_bad  = (in_data != HDR1) && (in_data != HDR0);
                end
                PIX:     state_nx = (load && last_pix) ? HUNT : PIX;
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            ch          <= 2'd0;
            pix_idx     <= '0;
            acc_rg      <= '0;
            tcnt        <= '0;
            pix_valid   <= 1'b0;
            pix_rgb     <= '0;
            pix_sof     <= 1'b0;
            pix_eof     <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            err_hdr     <= 1'b0;
        end else begin
            state       <= state_nx;
            err_hdr     <= hdr_bad;
            err_timeout <= timeout;
            frame_done  <= pix_valid && pix_ready && pix_eof;
            tcnt        <= (take || state == HUNT || timeout) ? '0 : idle_tick ? tcnt + 1'b1 : tcnt;
            if (timeout || (take && state == HDR)) begin
                ch      <= 2'd0;
                pix_idx <= '0;
            end else if (take && state == PIX) begin
                ch <= (ch == 2'd2) ? 2'd0 : ch + 2'd1;
                if (ch != 2'd2)
                    acc_rg[ch[0]*COLOR_DEPTH +: COLOR_DEPTH] <= chan;
                else
                    pix_idx <= last_pix ? '0 : pix_idx + 1'b1;
            end
            // a load always wins over a pop, giving back-to-back beats
            if (load) begin
                pix_valid <= 1'b1;
                pix_rgb   <= {chan, acc_rg};
                pix_sof   <= pix_idx == '0;
                pix_eof   <= last_pix;
            end else if (pix_valid && pix_ready)
                pix_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_pixel_framer.sv
// tb_uart_pixel_framer: randomized self-checking bench; a 4-bit and an 8-bit colour-depth
// framer (4x4 panel) share one byte stream and are compared every cycle with a byte-level model.
module tb_uart_pixel_framer;

    localparam int TO = 40;
    localparam int NP = 16;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, pix_ready = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready4, in_ready8, pv4, pv8, sof4, sof8, eof4, eof8;
    logic        fd4, fd8, et4, et8, eh4, eh8;
    logic [11:0] rgb4;
    logic [23:0] rgb8;

    always #5 clk = ~clk;

    uart_pixel_framer #(.COLOR_DEPTH(4), .PANEL_ROWS(4), .PANEL_COLS(4), .TIMEOUT_CYCLES(TO)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .pix_valid(pv4), .pix_ready(pix_ready), .pix_rgb(rgb4), .pix_sof(sof4), .pix_eof(eof4),
        .frame_done(fd4), .err_timeout(et4), .err_hdr(eh4));

    uart_pixel_framer #(.COLOR_DEPTH(8), .PANEL_ROWS(4), .PANEL_COLS(4), .TIMEOUT_CYCLES(TO)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .pix_valid(pv8), .pix_ready(pix_ready), .pix_rgb(rgb8), .pix_sof(sof8), .pix_eof(eof8),
        .frame_done(fd8), .err_timeout(et8), .err_hdr(eh8));

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: byte parser + one-slot output ----------------
    int          phase, idle, pix_n;
    logic [7:0]  ch_q[$];
    logic        e_valid, e_sof, e_eof, e_done, e_eto, e_eh, m_rdy, m_take, m_eto, m_eh;
    logic [11:0] e_rgb4;
    logic [23:0] e_rgb8;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0; idle = 0; pix_n = 0; ch_q.delete();
            e_valid = 0; e_sof = 0; e_eof = 0; e_done = 0; e_eto = 0; e_eh = 0;
            e_rgb4 = 0; e_rgb8 = 0;
        end else begin
            m_rdy  = !(e_valid && !pix_ready);
            m_take = in_valid && m_rdy;
            e_done = e_valid && pix_ready && e_eof;
            if (e_valid && pix_ready) e_valid = 0;
            m_eto = 0; m_eh = 0;
            if (m_take) begin
                idle = 0;
                if (phase == 0) begin
                    if (in_data == 8'hA5) phase = 1;
                end else if (phase == 1) begin
                    if (in_data == 8'h5A) begin phase = 2; pix_n = 0; ch_q.delete(); end
                    else if (in_data != 8'hA5) begin phase = 0; m_eh = 1; end
                end else begin
                    ch_q.push_back(in_data);
                    if (ch_q.size() == 3) begin
                        e_rgb4  = {ch_q[2][7:4], ch_q[1][7:4], ch_q[0][7:4]};
                        e_rgb8  = {ch_q[2], ch_q[1], ch_q[0]};
                        e_sof   = pix_n == 0;
                        e_eof   = pix_n == NP - 1;
                        e_valid = 1;
                        pix_n++;
                        ch_q.delete();
                        if (pix_n == NP) phase = 0;
                    end
                end
            end else if (phase != 0 && m_rdy) begin
                idle++;
                if (idle == TO) begin phase = 0; idle = 0; m_eto = 1; ch_q.delete(); end
            end
            if (phase == 0) idle = 0;
            e_eto = m_eto;
            e_eh  = m_eh;
        end
    end

    // ---------------- per-cycle compare + event counters ----------------
    int          beats = 0, sof_n = 0, eof_n = 0, done_n = 0, eto_n = 0, eh_n = 0;
    logic [11:0] last4 = 0;
    logic [23:0] last8 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready4", in_ready4, !(e_valid && !pix_ready));
            chk("in_ready8", in_ready8, !(e_valid && !pix_ready));
            chk("pix_valid4", pv4, e_valid);
            chk("pix_valid8", pv8, e_valid);
            chk("frame_done4", fd4, e_done);
            chk("frame_done8", fd8, e_done);
            chk("err_timeout4", et4, e_eto);
            chk("err_timeout8", et8, e_eto);
            chk("err_hdr4", eh4, e_eh);
            chk("err_hdr8", eh8, e_eh);
            if (e_valid) begin
                chk("pix_rgb4", rgb4, e_rgb4);
                chk("pix_rgb8", rgb8, e_rgb8);
                chk("pix_sof4", sof4, e_sof);
                chk("pix_sof8", sof8, e_sof);
                chk("pix_eof4", eof4, e_eof);
                chk("pix_eof8", eof8, e_eof);
            end
            if (pv4 && pix_ready) begin
                beats++; sof_n += int'(sof4); eof_n += int'(eof4); last4 = rgb4; last8 = rgb8;
            end
            done_n += int'(fd4); eto_n += int'(et4); eh_n += int'(eh4);
        end
    end

    // ---------------- stimulus ----------------
    logic hold = 1'b0, bp = 1'b0;

    initial forever begin
        @(posedge clk); #1;
        pix_ready = hold ? 1'b0 : bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // all driver tasks start and end at posedge+1
    task automatic send(input logic [7:0] b);
        logic r;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i <= 1000; i++) begin
            if (i == 1000) begin
                miscompares++;
                $display("FAIL send: byte %h not accepted in 1000 cycles", b);
                $fatal(1, "stuck");
            end
            @(negedge clk); r = in_ready4;
            @(posedge clk); #1;
            if (r) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_hdr();
        send(8'hA5); send(8'h5A);
    endtask

    // kind 0: constant R=F0 G=30 B=A0; kind 1: random bytes
    task automatic send_body(input int kind, input bit gaps, input int n);
        logic [7:0] fixed [3];
        fixed = '{8'hF0, 8'h30, 8'hA0};
        for (int i = 0; i < n; i++) begin
            send(kind == 0 ? fixed[i % 3] : 8'($urandom));
            if (gaps && $urandom_range(0, 7) == 0) gap($urandom_range(1, 10));
        end
    endtask

    int b0, s0, e0, d0, t0, h0, j;

    task automatic snap();
        b0 = beats; s0 = sof_n; e0 = eof_n; d0 = done_n; t0 = eto_n; h0 = eh_n;
    endtask

    initial begin
        #12;
        chk("reset pix_valid", pv4, 0);
        chk("reset in_ready", in_ready4, 1);
        chk("reset pix_rgb", rgb8, 0);
        chk("reset pulses", {fd4, et4, eh4, sof4, eof4}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        gap(2);

        // 1: fixed-colour frame
        snap();
        send_hdr(); send_body(0, 0, 3 * NP); gap(5);
        chk("t1 beats", beats - b0, NP);
        chk("t1 sof", sof_n - s0, 1);
        chk("t1 eof", eof_n - e0, 1);
        chk("t1 frame_done", done_n - d0, 1);
        chk("t1 rgb4", last4, 12'hA3F);
        chk("t1 rgb8", last8, 24'hA030F0);

        // 2: garbage before header, then a bad header
        snap();
        send(8'h11); send(8'h22); send(8'hA5); send(8'hA5); send(8'h5A);
        send_body(1, 0, 3 * NP); gap(5);
        chk("t2 err_hdr none", eh_n - h0, 0);
        chk("t2 beats", beats - b0, NP);
        send(8'hA5); send(8'h77); gap(3);
        chk("t2 err_hdr", eh_n - h0, 1);
        snap();
        send_hdr(); send_body(1, 0, 3 * NP); gap(5);
        chk("t2 after hdr err", beats - b0, NP);

        // 3: 20-cycle downstream stall mid-frame
        snap();
        send_hdr(); send_body(1, 0, 15);
        hold = 1'b1;
        fork
            send_body(1, 0, 3 * NP - 15);
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                chk("t3 stall in_ready", in_ready4, 0);
                chk("t3 stall pix_valid", pv4, 1);
                repeat (10) @(posedge clk);
                #1 hold = 1'b0;
            end
        join
        gap(5);
        chk("t3 beats", beats - b0, NP);
        chk("t3 no timeout", eto_n - t0, 0);

        // 4: abort after two channel bytes
        snap();
        send_hdr(); send(8'h12); send(8'h34);
        j = 0;
        for (int k = 0; k < 3 * TO; k++) begin
            @(negedge clk); j++;
            if (et4) break;
        end
        @(posedge clk); #1;
        chk("t4 timeout cycle", j, TO + 1);
        chk("t4 timeout pulses", eto_n - t0, 1);
        chk("t4 no beats", beats - b0, 0);
        send_hdr(); send_body(0, 0, 3 * NP); gap(5);
        chk("t4 resync beats", beats - b0, NP);
        chk("t4 resync sof", sof_n - s0, 1);
        chk("t4 resync rgb", last4, 12'hA3F);

        // 5: random frames, garbage, partial frames, random backpressure and gaps
        bp = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) send(8'($urandom));
            send_hdr();
            if (f % 3 == 2) begin
                send_body(1, 1, $urandom_range(1, 20));
                gap(TO + 5);
            end else
                send_body(1, 1, 3 * NP);
        end
        bp = 1'b0;
        gap(10);

        // 6: async reset while a beat is held
        hold = 1'b1;
        send_hdr(); send(8'hF0); send(8'h30); send(8'hA0); gap(2);
        chk("t6 held valid", pv4, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6 rst pix_valid", {pv4, pv8}, 0);
        chk("t6 rst pix_rgb", rgb8, 0);
        chk("t6 rst pix_rgb4", rgb4, 0);
        chk("t6 rst flags", {sof4, eof4, fd4, et4, eh4, sof8, eof8}, 0);
        hold = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        gap(2);
        snap();
        send_body(0, 0, 3 * NP); gap(5);
        chk("t6 hunt no beats", beats - b0, 0);
        send_hdr(); send_body(0, 0, 3 * NP); gap(5);
        chk("t6 resume beats", beats - b0, NP);
        chk("t6 resume sof", sof_n - s0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
